// File: rtl/datamem_sized.sv
// Byte-addressed data memory with sized, little-endian loads/stores and a valid/ready handshake.
// Define DATAMEM_CLEAR_EN to zero every word after reset (CLEAR state); otherwise contents power up undefined.
module datamem_sized #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);
    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DATAMEM_CLEAR_EN
    typedef enum logic [1:0] {StClear, StIdle, StResp} state_e;
    localparam state_e ResetState = StClear;
`else
    typedef enum logic [0:0] {StIdle, StResp} state_e;
    localparam state_e ResetState = StIdle;
`endif

    state_e state_q, state_d;

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [OFF_W-1:0]  offset;
    logic [OFF_W-1:0]  size_mask;
    logic [OFF_W-1:0]  lane;
    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        nbytes;
    logic              misaligned, out_of_range, oversize, req_err;
    logic              accept, store_we, sign;
    logic [XLEN-1:0]   cur_word, shifted, store_word, load_word;

    assign offset       = req_addr[OFF_W-1:0];
    assign word_idx     = req_addr >> OFF_W;
    assign idx          = word_idx[IDX_W-1:0];
    assign nbytes       = 4'd1 << req_size;
    assign size_mask    = OFF_W'(nbytes - 4'd1);
    assign misaligned   = |(offset & size_mask);
    assign out_of_range = word_idx >= ADDR_W'(DEPTH);
    assign oversize     = 32'(nbytes) > BYTES;
    assign req_err      = misaligned | out_of_range | oversize;
    assign accept       = req_valid & req_ready;
    assign store_we     = accept & req_we & ~req_err;

    assign cur_word = mem[idx];
    assign shifted  = cur_word >> {offset, 3'b000};

    // Position of word byte b within the request data, modulo the word size.
    function automatic logic [OFF_W-1:0] lane_of(input int unsigned b, input logic [OFF_W-1:0] off);
        return OFF_W'(b) - off;
    endfunction

    always_comb begin
        store_word = cur_word;
        load_word  = '0;
        lane       = '0;
        sign       = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            lane = lane_of(b, offset);
            // Aligned, in-size accesses never wrap, so the modular lane test is exact.
            if (32'(lane) < 32'(nbytes)) begin
                store_word[b*8 +: 8] = req_wdata[{lane, 3'b000} +: 8];
            end
            if (32'(b) == 32'(nbytes) - 32'd1) begin
                sign = shifted[b*8+7];
            end
        end
        for (int b = 0; b < BYTES; b++) begin
            if (32'(b) < 32'(nbytes)) begin
                load_word[b*8 +: 8] = shifted[b*8 +: 8];
            end else begin
                load_word[b*8 +: 8] = {8{sign & ~req_unsigned}};
            end
        end
    end

`ifdef DATAMEM_CLEAR_EN
    logic [IDX_W-1:0] clr_q;
    logic             clear_we, clr_done;

    assign clear_we = (state_q == StClear) & ~rst;
    assign clr_done = clr_q == IDX_W'(DEPTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_q <= '0;
        end else if (clear_we) begin
            clr_q <= clr_done ? '0 : clr_q + 1'b1;
        end
    end
`endif

    // Storage has no reset: rst must never disturb its contents.
    always_ff @(posedge clk) begin
`ifdef DATAMEM_CLEAR_EN
        if (clear_we) begin
            mem[clr_q] <= '0;
        end
`endif
        if (store_we) begin
            mem[idx] <= store_word;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            err_d   = req_err;
            rdata_d = (req_err | req_we) ? '0 : load_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ResetState;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef DATAMEM_CLEAR_EN
            StClear: if (clr_done) state_d = StIdle;
`endif
            StIdle:  if (req_valid) state_d = StResp;
            StResp:  if (resp_ready) state_d = StIdle;
            default: state_d = ResetState;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        if (!rst) begin
            case (state_q)
                StIdle: req_ready = 1'b1;
                StResp: begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata_q;
                    resp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_datamem_sized.sv
// Self-checking bench for datamem_sized: directed cases plus random traffic against a byte-array model.
module tb_datamem_sized;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [XLEN-1:0]   req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [DEPTH*8];

    always #5 clk = ~clk;

    datamem_sized #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory as a flat byte array: an access covers bytes addr..addr+2^size-1.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rd, output logic er);
        int nb;
        nb = 1 << size;
        rd = '0;
        er = (nb > XLEN / 8) || ((addr % 64'(nb)) != 64'd0) || (addr / (XLEN / 8) >= 64'(DEPTH));
        if (er) return;
        for (int i = 0; i < nb; i++) begin
            if (we) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            else    rd = rd | (64'(ref_mem[int'(addr) + i]) << (8 * i));
        end
        if (!we && !uns && rd[8*nb-1]) rd = rd | ({64{1'b1}} << (8 * nb));
    endtask

    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata, input int hold,
                       input bit use_exp, input logic [63:0] exp_d, input logic exp_e,
                       input string tag);
        logic [63:0] md;
        logic        me;
        int          w;
        model(we, size, uns, addr, wdata, md, me);
        if (use_exp) begin
            md = exp_d;
            me = exp_e;
        end
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        resp_ready   = 1'b0;
        w = 0;
        while (req_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "/req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        // Garbage on request fields outside the acceptance edge must not matter.
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};
        check({tag, "/resp_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "/rdata"}, resp_rdata, md);
        check({tag, "/err"}, 64'(resp_err), 64'(me));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 64'(resp_valid), 64'd1);
            check({tag, "/hold_rdata"}, resp_rdata, md);
            check({tag, "/hold_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "/done_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "/idle_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [63:0] a;
        int          r;
        int          cnt;

        #1;
        check("rst/req_ready", 64'(req_ready), 64'd0);
        check("rst/resp_valid", 64'(resp_valid), 64'd0);
        check("rst/rdata", resp_rdata, 64'd0);
        check("rst/err", 64'(resp_err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            txn(1'b1, 2'd3, 1'b0, 64'(i * 8), 64'd0, 0, 1'b0, 64'd0, 1'b0, "fill");
        end

        txn(1'b1, 2'd3, 1'b0, 64'h10, 64'h8877665544332211, 0, 1'b1, 64'd0, 1'b0, "st_d");
        txn(1'b0, 2'd0, 1'b1, 64'h17, 64'd0, 0, 1'b1, 64'h88, 1'b0, "ld_bu");
        txn(1'b0, 2'd0, 1'b0, 64'h17, 64'd0, 0, 1'b1, 64'hFFFFFFFFFFFFFF88, 1'b0, "ld_bs");
        txn(1'b1, 2'd1, 1'b0, 64'h12, 64'hABCD, 0, 1'b1, 64'd0, 1'b0, "st_h");
        txn(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, 1'b1, 64'h88776655ABCD2211, 1'b0, "ld_d");
        txn(1'b0, 2'd2, 1'b0, 64'h06, 64'd0, 0, 1'b1, 64'd0, 1'b1, "ld_mis");
        txn(1'b1, 2'd3, 1'b0, 64'h100, 64'hDEADBEEFCAFEF00D, 0, 1'b1, 64'd0, 1'b1, "st_oor");
        txn(1'b0, 2'd3, 1'b0, 64'h00, 64'd0, 0, 1'b1, 64'd0, 1'b0, "ld_unch");
        txn(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 3, 1'b1, 64'h88776655ABCD2211, 1'b0, "hold");

        for (int t = 0; t < 150; t++) begin
            sz = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            if (r == 0) a = {$urandom, $urandom};
            else        a = 64'($urandom_range(0, 271));
            if (r > 3)  a = a & ~(64'(1 << sz) - 64'd1);
            txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                $urandom_range(0, 2), 1'b0, 64'd0, 1'b0, "rand");
        end

        // Reset while a response is pending.
        txn(1'b1, 2'd3, 1'b0, 64'h10, 64'h0123456789ABCDEF, 0, 1'b0, 64'd0, 1'b0, "pre_rst");
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'd3;
        req_addr   = 64'h10;
        resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid/resp_valid", 64'(resp_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("arst/resp_valid", 64'(resp_valid), 64'd0);
        check("arst/req_ready", 64'(req_ready), 64'd0);
        check("arst/rdata", resp_rdata, 64'd0);
        check("arst/err", 64'(resp_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
`ifdef DATAMEM_CLEAR_EN
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("clear/cycles", 64'(cnt), 64'd32);
        for (int i = 0; i < DEPTH * 8; i++) ref_mem[i] = 8'h00;
        txn(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, 1'b1, 64'd0, 1'b0, "post_clear");
`else
        #1;
        check("post_rst/req_ready", 64'(req_ready), 64'd1);
        txn(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, 1'b0, 64'd0, 1'b0, "post_rst");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
